// File: rtl/grey_onehot_checker.sv
// grey_onehot_checker: consumer-side decoder and link-integrity monitor for a
// free-running Gray/one-hot counter. Two-stage pipeline: stage 1 captures the
// buses, stage 2 decodes, validates and runs the lock FSM.
`timescale 1ns/1ps

module grey_onehot_checker #(
  parameter int WIDTH      = 8,
  parameter int LOCK_COUNT = 4,
  parameter int ERR_CNT_W  = 8,
  parameter bit CHECK_HOT  = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic [WIDTH-1:0]         in_grey,
  input  logic [WIDTH-1:0]         in_hot,
  input  logic                     clr_err,
  output logic [WIDTH-1:0]         out_bin,
  output logic                     bin_valid,
  output logic                     hot_ok,
  output logic [$clog2(WIDTH)-1:0] hot_index,
  output logic                     locked,
  output logic                     seq_err,
  output logic [ERR_CNT_W-1:0]     err_count
);

  localparam int IW = $clog2(WIDTH);
  localparam int MW = $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {
    UNLOCKED,
    TRACKING,
    LOCKED
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] s1_grey;
  logic [WIDTH-1:0] s1_hot;
  logic             s1_valid;
  logic [WIDTH-1:0] expected_q;
  logic [WIDTH-1:0] prev_hot_q;
  logic [MW-1:0]    match_q;

  logic [WIDTH-1:0] bin_c;
  logic             hot_ok_c;
  logic [IW-1:0]    idx_c;
  logic             good_c;
  logic             match_reach_c;
  logic             err_event_c;

  assign locked = (state_q == LOCKED);

  // Stage 1: capture the buses on a sample strobe; valid follows en every edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_grey  <= '0;
      s1_hot   <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= en;
      if (en) begin
        s1_grey <= in_grey;
        s1_hot  <= in_hot;
      end
    end
  end

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it
  always_comb begin
    bin_c = '0;
    bin_c[WIDTH-1] = s1_grey[WIDTH-1];
    for (int unsigned i = 2; i <= WIDTH; i++) begin
      bin_c[WIDTH-i] = bin_c[WIDTH-i+1] ^ s1_grey[WIDTH-i];
    end
  end

  // One-hot validity (exactly one bit set) and index of the set bit
  always_comb begin
    hot_ok_c = (s1_hot != '0) && ((s1_hot & (s1_hot - WIDTH'(1))) == '0);
    idx_c    = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (s1_hot[i]) idx_c = IW'(i);
    end
    if (!hot_ok_c) idx_c = '0;
  end

  // Sequence continuity check against the value predicted by the previous sample
  always_comb begin
    good_c = (bin_c == expected_q);
    if (CHECK_HOT) begin
      good_c = good_c && hot_ok_c &&
               (s1_hot == {prev_hot_q[WIDTH-2:0], prev_hot_q[WIDTH-1]});
    end
    match_reach_c = ((32'(match_q) + 32'd1) >= 32'(LOCK_COUNT));
    err_event_c   = s1_valid && (state_q == LOCKED) && !good_c;
  end

  // Stage 2: registered outputs, prediction state, lock FSM and error counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_bin    <= '0;
      bin_valid  <= 1'b0;
      hot_ok     <= 1'b0;
      hot_index  <= '0;
      seq_err    <= 1'b0;
      err_count  <= '0;
      expected_q <= '0;
      prev_hot_q <= '0;
      match_q    <= '0;
      state_q    <= UNLOCKED;
    end else begin
      bin_valid <= s1_valid;
      seq_err   <= err_event_c;

      // clear wins, but an error landing in the same cycle still counts once
      if (clr_err) begin
        err_count <= err_event_c ? ERR_CNT_W'(1) : '0;
      end else if (err_event_c && (err_count != '1)) begin
        err_count <= err_count + ERR_CNT_W'(1);
      end

      if (s1_valid) begin
        out_bin    <= bin_c;
        hot_ok     <= hot_ok_c;
        hot_index  <= idx_c;
        expected_q <= bin_c + WIDTH'(1);
        prev_hot_q <= s1_hot;

        unique case (state_q)
          UNLOCKED: begin
            match_q <= MW'(1);
            state_q <= (LOCK_COUNT == 1) ? LOCKED : TRACKING;
          end
          TRACKING: begin
            if (good_c) begin
              if (match_reach_c) begin
                state_q <= LOCKED;
                match_q <= MW'(LOCK_COUNT);
              end else begin
                match_q <= match_q + MW'(1);
              end
            end else begin
              match_q <= MW'(1);
            end
          end
          LOCKED: begin
            if (!good_c) begin
              state_q <= TRACKING;
              match_q <= MW'(1);
            end
          end
          default: state_q <= UNLOCKED;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_grey_onehot_checker.sv
// Directed bench for grey_onehot_checker: a CHECK_HOT=1 instance and a
// CHECK_HOT=0 instance share the same stimulus.
`timescale 1ns/1ps

module tb_grey_onehot_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] in_grey = '0;
  logic [7:0] in_hot = '0;

  logic [7:0] out_bin, out_bin0;
  logic       bin_valid, bin_valid0;
  logic       hot_ok, hot_ok0;
  logic [2:0] hot_index, hot_index0;
  logic       locked, locked0;
  logic       seq_err, seq_err0;
  logic [7:0] err_count, err_count0;

  int total = 0;
  int bad_cnt = 0;
  logic [7:0] cur_b = '0;
  logic [7:0] cur_h = 8'h01;

  always #5 clk = ~clk;

  grey_onehot_checker #(.WIDTH(8), .LOCK_COUNT(4), .ERR_CNT_W(8), .CHECK_HOT(1'b1)) dut (
    .clk(clk), .reset(reset), .en(en), .in_grey(in_grey), .in_hot(in_hot),
    .clr_err(clr_err), .out_bin(out_bin), .bin_valid(bin_valid), .hot_ok(hot_ok),
    .hot_index(hot_index), .locked(locked), .seq_err(seq_err), .err_count(err_count)
  );

  grey_onehot_checker #(.WIDTH(8), .LOCK_COUNT(4), .ERR_CNT_W(8), .CHECK_HOT(1'b0)) dut0 (
    .clk(clk), .reset(reset), .en(en), .in_grey(in_grey), .in_hot(in_hot),
    .clr_err(clr_err), .out_bin(out_bin0), .bin_valid(bin_valid0), .hot_ok(hot_ok0),
    .hot_index(hot_index0), .locked(locked0), .seq_err(seq_err0), .err_count(err_count0)
  );

  function automatic logic [7:0] gray(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] h);
    return {h[6:0], h[7]};
  endfunction

  task automatic drive(input logic e, input logic [7:0] b, input logic [7:0] h);
    en = e;
    in_grey = gray(b);
    in_hot = h;
    @(posedge clk);
    #1;
  endtask

  task automatic feed_good();
    drive(1'b1, cur_b, cur_h);
    cur_b = cur_b + 8'd1;
    cur_h = rotl(cur_h);
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 8'h00);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_bin !== 8'h00) begin bad_cnt++; $display("FAIL reset_out_bin got=%0h exp=0", out_bin); end
    total++; if ({bin_valid, hot_ok, locked, seq_err} !== 4'b0000) begin bad_cnt++; $display("FAIL reset_flags got=%b exp=0000", {bin_valid, hot_ok, locked, seq_err}); end
    total++; if (err_count !== 8'h00) begin bad_cnt++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
    total++; if (hot_index !== 3'd0) begin bad_cnt++; $display("FAIL reset_hot_index got=%0d exp=0", hot_index); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_lock();
    int j;
    cur_b = 8'd0;
    cur_h = 8'h01;
    for (int i = 0; i <= 10; i++) begin
      feed_good();
      if (i > 0) begin
        j = i - 1;
        total++; if (out_bin !== 8'(j)) begin bad_cnt++; $display("FAIL lock_out_bin got=%0d exp=%0d", out_bin, j); end
        total++; if (bin_valid !== 1'b1) begin bad_cnt++; $display("FAIL lock_bin_valid got=%b exp=1 sample=%0d", bin_valid, j); end
        total++; if (hot_index !== 3'(j % 8)) begin bad_cnt++; $display("FAIL lock_hot_index got=%0d exp=%0d", hot_index, j % 8); end
        total++; if (locked !== (j >= 3)) begin bad_cnt++; $display("FAIL lock_locked got=%b exp=%b sample=%0d", locked, (j >= 3), j); end
        total++; if (seq_err !== 1'b0) begin bad_cnt++; $display("FAIL lock_seq_err got=%b exp=0 sample=%0d", seq_err, j); end
      end
    end
    idle();
    total++; if (out_bin !== 8'd10) begin bad_cnt++; $display("FAIL lock_last_bin got=%0d exp=10", out_bin); end
    total++; if (locked !== 1'b1) begin bad_cnt++; $display("FAIL lock_final got=%b exp=1", locked); end
    total++; if (err_count !== 8'd0) begin bad_cnt++; $display("FAIL lock_err_count got=%0d exp=0", err_count); end
    idle();
    total++; if (bin_valid !== 1'b0) begin bad_cnt++; $display("FAIL lock_valid_drop got=%b exp=0", bin_valid); end
    total++; if (out_bin !== 8'd10) begin bad_cnt++; $display("FAIL lock_hold_bin got=%0d exp=10", out_bin); end
  endtask

  task automatic test_wrap();
    int n;
    n = 256 - int'(cur_b) + 2;
    for (int k = 0; k < n; k++) begin
      feed_good();
      total++; if ({locked, seq_err} !== 2'b10) begin bad_cnt++; $display("FAIL wrap_lock got=%b exp=10 step=%0d", {locked, seq_err}, k); end
    end
    idle();
    total++; if (out_bin !== 8'd1) begin bad_cnt++; $display("FAIL wrap_bin got=%0d exp=1", out_bin); end
    total++; if ({bin_valid, locked, seq_err} !== 3'b110) begin bad_cnt++; $display("FAIL wrap_flags got=%b exp=110", {bin_valid, locked, seq_err}); end
    total++; if (locked0 !== 1'b1) begin bad_cnt++; $display("FAIL wrap_locked0 got=%b exp=1", locked0); end
  endtask

  task automatic test_skip();
    while (cur_b != 8'd21) feed_good();
    cur_b = 8'd22;
    drive(1'b1, cur_b, cur_h);
    cur_b = cur_b + 8'd1;
    cur_h = rotl(cur_h);
    total++; if ({out_bin, seq_err} !== {8'd20, 1'b0}) begin bad_cnt++; $display("FAIL skip_prev got=%0d/%b exp=20/0", out_bin, seq_err); end
    idle();
    total++; if ({bin_valid, seq_err} !== 2'b11) begin bad_cnt++; $display("FAIL skip_pulse got=%b exp=11", {bin_valid, seq_err}); end
    total++; if (out_bin !== 8'd22) begin bad_cnt++; $display("FAIL skip_bin got=%0d exp=22", out_bin); end
    total++; if (err_count !== 8'd1) begin bad_cnt++; $display("FAIL skip_err_count got=%0d exp=1", err_count); end
    total++; if (locked !== 1'b0) begin bad_cnt++; $display("FAIL skip_unlock got=%b exp=0", locked); end
    total++; if (err_count0 !== 8'd1) begin bad_cnt++; $display("FAIL skip_err_count0 got=%0d exp=1", err_count0); end
    idle();
    total++; if (seq_err !== 1'b0) begin bad_cnt++; $display("FAIL skip_single_pulse got=%b exp=0", seq_err); end
    feed_good();
    feed_good();
    total++; if (locked !== 1'b0) begin bad_cnt++; $display("FAIL skip_relock_early1 got=%b exp=0", locked); end
    feed_good();
    total++; if (locked !== 1'b0) begin bad_cnt++; $display("FAIL skip_relock_early2 got=%b exp=0", locked); end
    idle();
    total++; if (locked !== 1'b1) begin bad_cnt++; $display("FAIL skip_relock got=%b exp=1", locked); end
    total++; if (err_count !== 8'd1) begin bad_cnt++; $display("FAIL skip_err_hold got=%0d exp=1", err_count); end
  endtask

  task automatic test_hot();
    drive(1'b1, cur_b, 8'h00);
    cur_b = cur_b + 8'd1;
    cur_h = rotl(cur_h);
    idle();
    total++; if ({hot_ok, hot_index} !== 4'b0000) begin bad_cnt++; $display("FAIL hot_zero_flags got=%b/%0d exp=0/0", hot_ok, hot_index); end
    total++; if ({seq_err, locked} !== 2'b10) begin bad_cnt++; $display("FAIL hot_zero_break got=%b exp=10", {seq_err, locked}); end
    total++; if (out_bin !== cur_b - 8'd1) begin bad_cnt++; $display("FAIL hot_zero_bin got=%0d exp=%0d", out_bin, cur_b - 8'd1); end
    total++; if (err_count !== 8'd2) begin bad_cnt++; $display("FAIL hot_zero_err got=%0d exp=2", err_count); end
    total++; if ({locked0, seq_err0, hot_ok0} !== 3'b100) begin bad_cnt++; $display("FAIL hot_zero_nohot got=%b exp=100", {locked0, seq_err0, hot_ok0}); end
    repeat (4) feed_good();
    idle();
    total++; if ({locked, err_count} !== {1'b1, 8'd2}) begin bad_cnt++; $display("FAIL hot_recover1 got=%b/%0d exp=1/2", locked, err_count); end
    drive(1'b1, cur_b, 8'h41);
    cur_b = cur_b + 8'd1;
    cur_h = rotl(cur_h);
    idle();
    total++; if ({hot_ok, hot_index} !== 4'b0000) begin bad_cnt++; $display("FAIL hot_multi_flags got=%b/%0d exp=0/0", hot_ok, hot_index); end
    total++; if ({seq_err, err_count} !== {1'b1, 8'd3}) begin bad_cnt++; $display("FAIL hot_multi_break got=%b/%0d exp=1/3", seq_err, err_count); end
    total++; if ({locked0, seq_err0, err_count0} !== {2'b10, 8'd1}) begin bad_cnt++; $display("FAIL hot_multi_nohot got=%b%b/%0d exp=10/1", locked0, seq_err0, err_count0); end
    repeat (4) feed_good();
    idle();
    total++; if ({locked, err_count} !== {1'b1, 8'd3}) begin bad_cnt++; $display("FAIL hot_recover2 got=%b/%0d exp=1/3", locked, err_count); end
  endtask

  task automatic test_saturate();
    repeat (256) begin
      cur_b = cur_b + 8'd1;
      feed_good();
      repeat (3) feed_good();
    end
    idle();
    total++; if (err_count !== 8'd255) begin bad_cnt++; $display("FAIL sat_err got=%0d exp=255", err_count); end
    total++; if (err_count0 !== 8'd255) begin bad_cnt++; $display("FAIL sat_err0 got=%0d exp=255", err_count0); end
    total++; if (locked !== 1'b1) begin bad_cnt++; $display("FAIL sat_locked got=%b exp=1", locked); end
    cur_b = cur_b + 8'd1;
    feed_good();
    clr_err = 1'b1;
    idle();
    clr_err = 1'b0;
    total++; if ({seq_err, err_count} !== {1'b1, 8'd1}) begin bad_cnt++; $display("FAIL clr_with_err got=%b/%0d exp=1/1", seq_err, err_count); end
    total++; if (err_count0 !== 8'd1) begin bad_cnt++; $display("FAIL clr_with_err0 got=%0d exp=1", err_count0); end
    clr_err = 1'b1;
    idle();
    clr_err = 1'b0;
    total++; if (err_count !== 8'd0) begin bad_cnt++; $display("FAIL clr_alone got=%0d exp=0", err_count); end
    repeat (3) feed_good();
    idle();
    total++; if (locked !== 1'b1) begin bad_cnt++; $display("FAIL clr_relock got=%b exp=1", locked); end
  endtask

  task automatic test_gaps();
    logic [7:0] a;
    a = cur_b;
    feed_good();
    idle();
    total++; if ({bin_valid, out_bin} !== {1'b1, a}) begin bad_cnt++; $display("FAIL gap_first got=%b/%0d exp=1/%0d", bin_valid, out_bin, a); end
    idle();
    total++; if ({bin_valid, out_bin, locked} !== {1'b0, a, 1'b1}) begin bad_cnt++; $display("FAIL gap_hold got=%b/%0d/%b exp=0/%0d/1", bin_valid, out_bin, locked, a); end
    feed_good();
    total++; if ({bin_valid, out_bin} !== {1'b0, a}) begin bad_cnt++; $display("FAIL gap_hold2 got=%b/%0d exp=0/%0d", bin_valid, out_bin, a); end
    idle();
    total++; if ({bin_valid, out_bin} !== {1'b1, a + 8'd1}) begin bad_cnt++; $display("FAIL gap_resume got=%b/%0d exp=1/%0d", bin_valid, out_bin, a + 8'd1); end
    total++; if ({locked, seq_err} !== 2'b10) begin bad_cnt++; $display("FAIL gap_lock got=%b exp=10", {locked, seq_err}); end
  endtask

  task automatic test_reset_mid();
    feed_good();
    #2 reset = 1'b0;
    #1;
    total++; if (out_bin !== 8'h00) begin bad_cnt++; $display("FAIL rst_mid_bin got=%0d exp=0", out_bin); end
    total++; if ({bin_valid, hot_ok, locked, seq_err, hot_index} !== 7'd0) begin bad_cnt++; $display("FAIL rst_mid_flags got=%b exp=0", {bin_valid, hot_ok, locked, seq_err, hot_index}); end
    total++; if ({locked0, out_bin0} !== 9'd0) begin bad_cnt++; $display("FAIL rst_mid_dut0 got=%b/%0d exp=0/0", locked0, out_bin0); end
    @(negedge clk);
    reset = 1'b1;
    feed_good();
    feed_good();
    total++; if (locked !== 1'b0) begin bad_cnt++; $display("FAIL rst_relock1 got=%b exp=0", locked); end
    feed_good();
    total++; if (locked !== 1'b0) begin bad_cnt++; $display("FAIL rst_relock2 got=%b exp=0", locked); end
    feed_good();
    total++; if (locked !== 1'b0) begin bad_cnt++; $display("FAIL rst_relock3 got=%b exp=0", locked); end
    idle();
    total++; if ({locked, out_bin} !== {1'b1, cur_b - 8'd1}) begin bad_cnt++; $display("FAIL rst_relock4 got=%b/%0d exp=1/%0d", locked, out_bin, cur_b - 8'd1); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_wrap();
    test_skip();
    test_hot();
    test_saturate();
    test_gaps();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad_cnt);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
